// File: rtl/interval_timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : interval_timer_ctrl
// Brief    : Two-requester round-robin controller for a shared 4-bit loadable
//            up-counter. A granted requester's start value is loaded into
//            the counter, and the interval ends when the counter reaches TERM.
// Revision : 1.0 - initial release
// ============================================================================
module interval_timer_ctrl #(
  parameter logic [3:0] TERM = 4'hF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  input  logic [3:0] start0,
  input  logic [3:0] start1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       done0,
  output logic       done1,
  output logic       busy,
  output logic       cnt_load,
  output logic [3:0] cnt_din,
  input  logic [3:0] cnt_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic       ptr_q,   ptr_d;    // requester favoured when both ask
  logic       sel_q,   sel_d;    // requester owning the current interval
  logic [3:0] start_q, start_d;  // start value captured at grant

  logic       pick;              // arbitration result in IDLE
  logic       sel_req;           // request line of the current owner

  // Round-robin pick: a lone requester always wins; a tie goes to the pointer
  always_comb begin
    pick    = 1'b0;
    sel_req = 1'b0;
    if (req0 && req1) begin
      pick = ptr_q;
    end else begin
      pick = req1;
    end
    sel_req = sel_q ? req1 : req0;
  end

  // State register; reset overrides everything, including an active interval
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      ptr_q   <= 1'b0;
      sel_q   <= 1'b0;
      start_q <= 4'h0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      start_q <= start_d;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    sel_d    = sel_q;
    start_d  = start_q;
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    done0    = 1'b0;
    done1    = 1'b0;
    busy     = 1'b0;
    cnt_load = 1'b0;
    cnt_din  = 4'h0;

    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          sel_d   = pick;
          start_d = pick ? start1 : start0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        cnt_load = 1'b1;
        cnt_din  = start_q;
        state_d  = S_RUN;
      end
      S_RUN: begin
        // A dropped request ends the interval silently, even on the terminal cycle
        if (!sel_req) begin
          ptr_d   = ~sel_q;
          state_d = S_IDLE;
        end else if (cnt_count == TERM) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done0   = ~sel_q;
        done1   = sel_q;
        ptr_d   = ~sel_q;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (state_q != S_IDLE) begin
      busy = 1'b1;
      gnt0 = ~sel_q;
      gnt1 = sel_q;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_interval_timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_interval_timer_ctrl
// Brief    : Self-checking bench for interval_timer_ctrl. Directed scenarios
//            plus randomized requesters compared against an interval-level
//            reference model (grant edge + offset arithmetic).
// Revision : 1.0 - initial release
// ============================================================================
module tb_interval_timer_ctrl;

  localparam logic [3:0] TERM_A = 4'hF;
  localparam logic [3:0] TERM_B = 4'h3;

  logic       clk = 1'b0;

  // Main instance (TERM = F)
  logic       rst = 1'b0, req0 = 1'b0, req1 = 1'b0;
  logic [3:0] start0 = 4'h0, start1 = 4'h0;
  logic       gnt0, gnt1, done0, done1, busy, cnt_load;
  logic [3:0] cnt_din;
  logic [3:0] cnt_count = 4'h0;

  // Second instance (TERM = 3) for wrap-around interval lengths
  logic       b_rst = 1'b0, b_req0 = 1'b0, b_req1 = 1'b0;
  logic [3:0] b_start0 = 4'h0, b_start1 = 4'h0;
  logic       b_gnt0, b_gnt1, b_done0, b_done1, b_busy, b_cnt_load;
  logic [3:0] b_cnt_din;
  logic [3:0] b_cnt_count = 4'h0;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: one interval at a time, described by its grant edge
  bit         m_active = 1'b0;
  bit         m_owner  = 1'b0;
  bit         m_ptr    = 1'b0;
  logic [3:0] m_start  = 4'h0;
  int         m_gedge  = 0;
  int         m_len    = 0;   // (TERM - start) mod 16
  int         cyc      = 0;
  logic       e_gnt0 = 1'b0, e_gnt1 = 1'b0, e_done0 = 1'b0, e_done1 = 1'b0;
  logic       e_busy = 1'b0, e_load = 1'b0;
  logic [3:0] e_din  = 4'h0;

  interval_timer_ctrl #(.TERM(TERM_A)) u_dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1),
    .start0(start0), .start1(start1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .busy(busy), .cnt_load(cnt_load), .cnt_din(cnt_din), .cnt_count(cnt_count)
  );

  interval_timer_ctrl #(.TERM(TERM_B)) u_dut_b (
    .clk(clk), .rst(b_rst), .req0(b_req0), .req1(b_req1),
    .start0(b_start0), .start1(b_start1),
    .gnt0(b_gnt0), .gnt1(b_gnt1), .done0(b_done0), .done1(b_done1),
    .busy(b_busy), .cnt_load(b_cnt_load), .cnt_din(b_cnt_din), .cnt_count(b_cnt_count)
  );

  always #5 clk = ~clk;

  // Shared loadable up-counters attached to each controller
  always @(posedge clk) begin
    if (cnt_load) cnt_count <= cnt_din;
    else          cnt_count <= cnt_count + 4'h1;
    if (b_cnt_load) b_cnt_count <= b_cnt_din;
    else            b_cnt_count <= b_cnt_count + 4'h1;
  end

  // Advance the model across one posedge using the inputs the DUT sampled,
  // then derive the expected outputs of the new cycle from the interval offset.
  // Offsets: 0 = load, 1..len+1 = counting, len+2 = completion.
  task automatic model_edge();
    int off;
    if (!rst) begin
      m_active = 1'b0;
      m_ptr    = 1'b0;
    end else if (!m_active) begin
      if (req0 || req1) begin
        m_owner  = (req0 && req1) ? m_ptr : req1;
        m_start  = m_owner ? start1 : start0;
        m_len    = (int'(TERM_A) - int'(m_start) + 16) % 16;
        m_gedge  = cyc + 1;
        m_active = 1'b1;
      end
    end else begin
      off = cyc - m_gedge;
      if (off >= 1 && off <= m_len + 1 && !(m_owner ? req1 : req0)) begin
        m_active = 1'b0;
        m_ptr    = !m_owner;
      end else if (off == m_len + 2) begin
        m_active = 1'b0;
        m_ptr    = !m_owner;
      end
    end
    cyc++;
    off     = cyc - m_gedge;
    e_busy  = m_active;
    e_gnt0  = m_active && !m_owner;
    e_gnt1  = m_active && m_owner;
    e_load  = m_active && (off == 0);
    e_din   = e_load ? m_start : 4'h0;
    e_done0 = m_active && (off == m_len + 2) && !m_owner;
    e_done1 = m_active && (off == m_len + 2) && m_owner;
  endtask

  // Drive inputs for the next posedge of the main instance, advance the model,
  // and return at the following negedge where outputs are stable.
  task automatic step(input logic r, input logic q0, input logic q1,
                      input logic [3:0] s0, input logic [3:0] s1);
    rst = r; req0 = q0; req1 = q1; start0 = s0; start1 = s1;
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic test_reset();
    step(1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
    step(1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
    n_checks++;
    if ({gnt0, gnt1, done0, done1, busy, cnt_load, cnt_din} !== 10'b0) begin
      n_fail++;
      $display("FAIL reset_outputs got=%b exp=%b",
               {gnt0, gnt1, done0, done1, busy, cnt_load, cnt_din}, 10'b0);
    end
    // requests while reset is held must not be granted
    step(1'b0, 1'b1, 1'b1, 4'h3, 4'h4);
    n_checks++;
    if ({gnt0, gnt1, busy, cnt_load} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_blocks_req got=%b exp=0000", {gnt0, gnt1, busy, cnt_load});
    end
  endtask

  // start0=C with TERM=F: done0 in the cycle after grant-edge+5
  task automatic test_single();
    logic       eg, ed, el;
    logic [3:0] edin;
    step(1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, (i <= 6), 1'b0, 4'hC, 4'h0);
      eg   = (i <= 6);
      ed   = (i == 6);
      el   = (i == 1);
      edin = (i == 1) ? 4'hC : 4'h0;
      n_checks++;
      if ({gnt0, gnt1, done0, done1, busy, cnt_load, cnt_din} !==
          {eg, 1'b0, ed, 1'b0, eg, el, edin}) begin
        n_fail++;
        $display("FAIL single_cycle%0d got=%b exp=%b", i,
                 {gnt0, gnt1, done0, done1, busy, cnt_load, cnt_din},
                 {eg, 1'b0, ed, 1'b0, eg, el, edin});
      end
    end
  endtask

  // Both held from reset with start=E: completions alternate 0,1,0,1,...
  task automatic test_back_to_back();
    int ndone;
    ndone = 0;
    step(1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
    for (int i = 1; i <= 30; i++) begin
      step(1'b1, 1'b1, 1'b1, 4'hE, 4'hE);
      n_checks++;
      if (gnt0 && gnt1) begin
        n_fail++;
        $display("FAIL b2b_overlap cycle%0d got gnt0=%b gnt1=%b exp not both", i, gnt0, gnt1);
      end
      n_checks++;
      if ({gnt0, gnt1, done0, done1, busy} !== {e_gnt0, e_gnt1, e_done0, e_done1, e_busy}) begin
        n_fail++;
        $display("FAIL b2b_model cycle%0d got=%b exp=%b", i,
                 {gnt0, gnt1, done0, done1, busy}, {e_gnt0, e_gnt1, e_done0, e_done1, e_busy});
      end
      if (done0 || done1) begin
        n_checks++;
        if (done1 !== (ndone % 2 == 1)) begin
          n_fail++;
          $display("FAIL b2b_order done#%0d got done1=%b exp=%b", ndone, done1, (ndone % 2 == 1));
        end
        ndone++;
      end
    end
    n_checks++;
    if (ndone < 5) begin
      n_fail++;
      $display("FAIL b2b_count got=%0d exp>=5", ndone);
    end
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 4'h0, 4'h0);
  endtask

  // req1 dropped while counting: silent return to idle, pointer back to 0
  task automatic test_abort();
    step(1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 4'h0, 4'h0);
    n_checks++;
    if ({gnt1, busy} !== 2'b11) begin
      n_fail++;
      $display("FAIL abort_running got gnt1,busy=%b exp=11", {gnt1, busy});
    end
    step(1'b1, 1'b0, 1'b0, 4'h0, 4'h0);
    n_checks++;
    if ({gnt0, gnt1, done0, done1, busy} !== 5'b0) begin
      n_fail++;
      $display("FAIL abort_idle got=%b exp=00000", {gnt0, gnt1, done0, done1, busy});
    end
    step(1'b1, 1'b1, 1'b1, 4'hE, 4'hE);
    n_checks++;
    if ({gnt0, gnt1} !== 2'b10) begin
      n_fail++;
      $display("FAIL abort_pointer got gnt0,gnt1=%b exp=10", {gnt0, gnt1});
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 1'b0, 4'h0, 4'h0);
      n_checks++;
      if ({gnt0, gnt1, done0, done1, busy} !== {e_gnt0, e_gnt1, e_done0, e_done1, e_busy}) begin
        n_fail++;
        $display("FAIL abort_drain step%0d got=%b exp=%b", i,
                 {gnt0, gnt1, done0, done1, busy}, {e_gnt0, e_gnt1, e_done0, e_done1, e_busy});
      end
    end
  endtask

  // Reset while counting at 7, then a fresh request completes normally
  task automatic test_reset_mid_run();
    int got, ndone;
    got = -1; ndone = 0;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 4'h5, 4'h0);
    n_checks++;
    if ({cnt_count, busy, gnt0} !== {4'h7, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL rstrun_pre got cnt,busy,gnt0=%h,%b,%b exp=7,1,1", cnt_count, busy, gnt0);
    end
    step(1'b0, 1'b1, 1'b0, 4'h5, 4'h0);
    n_checks++;
    if ({gnt0, gnt1, done0, done1, busy, cnt_load, cnt_din} !== 10'b0) begin
      n_fail++;
      $display("FAIL rstrun_outputs got=%b exp=%b",
               {gnt0, gnt1, done0, done1, busy, cnt_load, cnt_din}, 10'b0);
    end
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, (i <= 13), 1'b0, 4'h5, 4'h0);
      if (done0) begin
        ndone++;
        if (got < 0) got = i;
      end
    end
    n_checks++;
    if (got != 13 || ndone != 1) begin
      n_fail++;
      $display("FAIL rstrun_fresh got done at %0d (%0d pulses) exp at 13 (1 pulse)", got, ndone);
    end
  endtask

  // start0 wiggled while counting must not change the interval (start 8 -> 10 cycles)
  task automatic test_start_change();
    int got;
    got = -1;
    for (int i = 1; i <= 12; i++) begin
      step(1'b1, (i <= 10), 1'b0, (i == 1) ? 4'h8 : 4'($urandom_range(0, 15)), 4'h0);
      if (done0 && got < 0) got = i;
    end
    n_checks++;
    if (got != 10) begin
      n_fail++;
      $display("FAIL start_change got done at %0d exp at 10", got);
    end
  endtask

  // TERM=3: start 0 -> 4 counting edges, start 5 -> 15 (wraps through F->0)
  task automatic test_wrap();
    logic [3:0] sv [2];
    int         ev [2];
    int         got;
    sv[0] = 4'h0; ev[0] = 6;
    sv[1] = 4'h5; ev[1] = 17;
    b_rst = 1'b0;
    @(posedge clk); @(negedge clk);
    b_rst = 1'b1;
    for (int t = 0; t < 2; t++) begin
      b_req0 = 1'b1; b_start0 = sv[t];
      got = -1;
      for (int i = 1; i <= 24 && got < 0; i++) begin
        @(posedge clk); @(negedge clk);
        if (b_done0) got = i;
      end
      n_checks++;
      if (got != ev[t]) begin
        n_fail++;
        $display("FAIL wrap_start%h got done at %0d exp at %0d", sv[t], got, ev[t]);
      end
      b_req0 = 1'b0;
      @(posedge clk); @(negedge clk);
      n_checks++;
      if ({b_done0, b_busy, b_gnt0} !== 3'b000) begin
        n_fail++;
        $display("FAIL wrap_pulse%0d got done0,busy,gnt0=%b exp=000", t, {b_done0, b_busy, b_gnt0});
      end
    end
  endtask

  // Randomized requesters (holding, re-requesting, aborting, changing start,
  // rare resets) checked every cycle against the model
  task automatic test_random();
    logic       r, q0, q1;
    logic [3:0] s0, s1;
    q0 = 1'b0; q1 = 1'b0; s0 = 4'h0; s1 = 4'h0;
    for (int n = 0; n < 800; n++) begin
      r = ($urandom_range(0, 299) != 0);
      if (q0) begin
        if (e_done0) q0 = ($urandom_range(0, 3) == 0);
        else if ($urandom_range(0, 59) == 0) q0 = 1'b0;
      end else begin
        q0 = ($urandom_range(0, 3) == 0);
      end
      if (q1) begin
        if (e_done1) q1 = ($urandom_range(0, 3) == 0);
        else if ($urandom_range(0, 59) == 0) q1 = 1'b0;
      end else begin
        q1 = ($urandom_range(0, 3) == 0);
      end
      if ($urandom_range(0, 3) == 0) s0 = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) s1 = 4'($urandom_range(0, 15));
      step(r, q0, q1, s0, s1);
      n_checks++;
      if ({gnt0, gnt1, done0, done1, busy, cnt_load, cnt_din} !==
          {e_gnt0, e_gnt1, e_done0, e_done1, e_busy, e_load, e_din}) begin
        n_fail++;
        $display("FAIL rand_cycle%0d got=%b exp=%b", n,
                 {gnt0, gnt1, done0, done1, busy, cnt_load, cnt_din},
                 {e_gnt0, e_gnt1, e_done0, e_done1, e_busy, e_load, e_din});
      end
      n_checks++;
      if (gnt0 && gnt1) begin
        n_fail++;
        $display("FAIL rand_overlap cycle%0d got gnt0=%b gnt1=%b exp not both", n, gnt0, gnt1);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_abort();
    test_reset_mid_run();
    test_start_change();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/interval_timer_ctrl.md
INTERVAL_TIMER_CTRL -- requirements
Module: interval_timer_ctrl

Interface
REQ-001 Parameter TERM, default 4'hF, terminal count at which a timed interval ends.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, synchronous, active-low.
REQ-004 req0, req1  input  1 each  requester 0/1 asks for a timed interval; held high until its done pulse.
REQ-005 start0, start1  input  4 each  start value for requester 0/1; sampled only at grant.
REQ-006 gnt0, gnt1  output  1 each  one-hot grant; high from LOAD through DONE for the selected requester.
REQ-007 done0, done1  output  1 each  one-cycle completion pulse to the selected requester.
REQ-008 busy  output  1  high in any state other than IDLE.
REQ-009 cnt_load  output  1  load strobe to the shared 4-bit loadable up-counter.
REQ-010 cnt_din  output  4  load value to the counter.
REQ-011 cnt_count  input  4  current counter value; the counter increments by 1 every cycle cnt_load is low and wraps 4'hF->4'h0.

Function
REQ-012 FSM states: IDLE, LOAD, RUN, DONE; exactly one active.
REQ-013 IDLE: if any req high, register selected index and its start value, go LOAD; else stay.
REQ-014 Arbitration round-robin via 1-bit pointer; both req high -> grant the requester the pointer names; one req high -> grant it regardless of pointer.
REQ-015 LOAD: cnt_load=1, cnt_din=latched start value, for exactly one cycle; next state RUN.
REQ-016 cnt_load=0 and cnt_din=4'h0 in every state other than LOAD.
REQ-017 RUN: cnt_count==TERM -> DONE; granted req low (abort) -> IDLE, no done pulse; abort takes precedence when both are true in the same cycle.
REQ-018 DONE: drive done of the selected requester for one cycle; pointer set to the other requester; next state IDLE.
REQ-019 Abort also sets the pointer to the other requester.
REQ-020 Interval length: DONE entered (TERM - start) mod 16 + 1 edges after the first RUN edge; start==TERM gives the shortest interval, start==TERM+1 (mod 16) the longest, counted through wrap 4'hF->4'h0.
REQ-021 Latency: req sampled at edge E -> LOAD after E, counter==start after E+1, done high in the cycle after edge E+2+((TERM-start) mod 16).
REQ-022 gnt0 and gnt1 never both high; done only ever accompanies the matching gnt.
REQ-023 The requester of a request still high in IDLE after its done is treated as a new request.
REQ-024 Changes on start0/start1 after the grant edge do not affect the running interval.

Reset
REQ-025 rst low at a posedge -> next cycle state IDLE, pointer=0, gnt0=gnt1=0, done0=done1=0, busy=0, cnt_load=0, cnt_din=4'h0.
REQ-026 Reset wins over every other condition, including mid-LOAD/RUN/DONE; no done pulse is generated for the interrupted interval.
REQ-027 The controller does not reset the counter; the first LOAD after reset defines its value.

Verification
REQ-028 req0=1, start0=4'hC, TERM=F, counter model attached -> gnt0 from edge E+1, cnt_load one cycle with cnt_din=C, done0 single pulse in the cycle after edge E+5, busy low afterwards.
REQ-029 req0 and req1 high together from reset, start=4'hE each -> req0 served first, then req1, alternating while both are held; gnt never overlaps.
REQ-030 start0=4'h0, TERM=4'h3 and start0=4'h5, TERM=4'h3 -> done after 4 and 15 RUN edges respectively (wrap-around case).
REQ-031 req1 dropped mid-RUN -> next cycle IDLE, no done1, gnt1 low, pointer=0.
REQ-032 rst low during RUN with count at 4'h7 -> all outputs at reset values next cycle, no done; a fresh req after reset completes normally.
REQ-033 start0 changed during RUN -> interval length unchanged.
